nn_layer_ctrl: RTL and testbench

//  Sequencer for one fully-connected layer instance. Fetches NUM_INPUTS activations from the

---
 rtl/nn_layer_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_nn_layer_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_ctrl.sv
// nn_layer_ctrl: sequencer for one fully-connected layer instance.
//
// Streams NUM_INPUTS activations from an input buffer into the layer. The weight
// index goes out together with each buffer read. The controller then waits for
// every neuron to raise its out_valid bit. The pass ends in one of three ways:
// a one-cycle layer_done pulse, a sticky timeout fault, or an abort.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   start        begin one layer pass (honoured in IDLE only)
//   abort        return to IDLE from any state; discards a read in flight
//   in_avail     input buffer holds the next activation
//   in_rd_en     buffer read strobe
//   in_rd_addr   buffer read index
//   in_rd_data   buffer data, valid one cycle after in_rd_en
//   local_addr   weight index to the layer memories (held while idle/stalled)
//   data_in      activation to the layer
//   input_valid  data_in qualifier (in_rd_en delayed one cycle)
//   out_valids   per-neuron completion flags from the layer
//   busy         high in every state except IDLE
//   layer_done   one-cycle pulse when all neurons report valid
//   fault        sticky timeout flag, cleared by an accepted start or rst
module nn_layer_ctrl #(
  parameter int unsigned NUM_INPUTS  = 784,
  parameter int unsigned NUM_NEURONS = 128,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_avail,
  output logic                   in_rd_en,
  output logic [31:0]            in_rd_addr,
  input  logic [DATA_WIDTH-1:0]  in_rd_data,
  output logic [31:0]            local_addr,
  output logic [DATA_WIDTH-1:0]  data_in,
  output logic                   input_valid,
  input  logic [NUM_NEURONS-1:0] out_valids,
  output logic                   busy,
  output logic                   layer_done,
  output logic                   fault
);

  localparam logic [31:0]     LastIdx = 32'(NUM_INPUTS - 1);
  localparam int unsigned     TmoW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStream,
    StDrain,
    StWait,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [31:0]     cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            rd_en_q, rd_en_d;
  logic [31:0]     rd_addr_q, rd_addr_d;
  logic [31:0]     local_addr_q, local_addr_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;

  logic start_accept;
  logic issue;
  logic last_issue;
  logic all_valid;
  logic tmo_expire;

  // Decoded events. abort suppresses everything that would advance the pass.
  always_comb begin
    start_accept = (state_q == StIdle) && start && !abort;
    issue        = (state_q == StStream) && in_avail && !abort;
    last_issue   = issue && (cnt_q == LastIdx);
    all_valid    = &out_valids;
    tmo_expire   = (state_q == StWait) && !all_valid && (tmo_q == TmoLast) && !abort;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) state_d = StStream;
        end
        StStream: begin
          if (last_issue) state_d = StDrain;
        end
        // The final read is on the bus this cycle; its input_valid follows.
        StDrain: begin
          state_d = StWait;
        end
        StWait: begin
          // Completion wins over a timeout landing on the same cycle.
          if (all_valid) begin
            state_d = StDone;
          end else if (tmo_q == TmoLast) begin
            state_d = StIdle;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy       = (state_q != StIdle);
    layer_done = (state_q == StDone);
    // Buffer data arrives the cycle after the read, the same cycle input_valid rises.
    // Gating keeps data_in at zero outside valid cycles.
    data_in    = valid_q ? in_rd_data : '0;
  end

  assign in_rd_en    = rd_en_q;
  assign in_rd_addr  = rd_addr_q;
  assign local_addr  = local_addr_q;
  assign input_valid = valid_q;
  assign fault       = fault_q;

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (abort || start_accept) begin
      cnt_d = '0;
    end else if (issue && !last_issue) begin
      // Held at the last index once issued; never exceeds NUM_INPUTS-1.
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == StDrain) begin
      tmo_d = '0;
    end else if ((state_q == StWait) && !all_valid && (tmo_q != TmoLast)) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_comb begin
    rd_en_d      = issue;
    rd_addr_d    = issue ? cnt_q : rd_addr_q;
    // Weight memory read is registered, so weight k lines up with data k on input_valid.
    local_addr_d = issue ? cnt_q : local_addr_q;
    // A read in flight when abort hits never produces an input_valid.
    valid_d      = rd_en_q && !abort;
  end

  always_comb begin
    fault_d = fault_q;
    if (start_accept) begin
      fault_d = 1'b0;
    end else if (tmo_expire) begin
      fault_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      tmo_q        <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      local_addr_q <= '0;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      local_addr_q <= local_addr_d;
      valid_q      <= valid_d;
      fault_q      <= fault_d;
    end
  end

endmodule

// File: tb/tb_nn_layer_ctrl.sv
module tb_nn_layer_ctrl;

  localparam int unsigned NI = 4;
  localparam int unsigned NN = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          in_avail;
  logic          in_rd_en;
  logic [31:0]   in_rd_addr;
  logic [DW-1:0] in_rd_data = '0;
  logic [31:0]   local_addr;
  logic [DW-1:0] data_in;
  logic          input_valid;
  logic [NN-1:0] out_valids;
  logic          busy;
  logic          layer_done;
  logic          fault;

  int n_cmp  = 0;
  int n_fail = 0;
  int iv_cnt = 0;
  int done_cnt = 0;
  int iv_base;
  int done_base;

  always #5 clk = ~clk;

  nn_layer_ctrl #(
    .NUM_INPUTS (NI),
    .NUM_NEURONS(NN),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .in_avail   (in_avail),
    .in_rd_en   (in_rd_en),
    .in_rd_addr (in_rd_addr),
    .in_rd_data (in_rd_data),
    .local_addr (local_addr),
    .data_in    (data_in),
    .input_valid(input_valid),
    .out_valids (out_valids),
    .busy       (busy),
    .layer_done (layer_done),
    .fault      (fault)
  );

  // Input buffer: one-cycle read latency, word k holds 0xA000 + k.
  always @(posedge clk) begin
    if (in_rd_en) in_rd_data <= 16'hA000 + in_rd_addr[15:0];
  end

  // Pulse counters.
  always @(posedge clk) begin
    if (input_valid) iv_cnt <= iv_cnt + 1;
    if (layer_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, " busy"},        32'(busy),        32'd0);
    check({pfx, " in_rd_en"},    32'(in_rd_en),    32'd0);
    check({pfx, " input_valid"}, 32'(input_valid), 32'd0);
    check({pfx, " layer_done"},  32'(layer_done),  32'd0);
    check({pfx, " fault"},       32'(fault),       32'd0);
    check({pfx, " in_rd_addr"},  in_rd_addr,       32'd0);
    check({pfx, " local_addr"},  local_addr,       32'd0);
    check({pfx, " data_in"},     32'(data_in),     32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    in_avail   = 1'b0;
    out_valids = '0;
    step();
    step();
    check_reset("reset");
    rst = 1'b0;
    step();

    // Streaming with the buffer always ready.
    iv_base  = iv_cnt;
    in_avail = 1'b1;
    start    = 1'b1;
    step();
    start = 1'b0;
    check("t1 busy after start", 32'(busy), 32'd1);
    check("t1 no read yet", 32'(in_rd_en), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t1 rd_en %0d", k), 32'(in_rd_en), 32'd1);
      check($sformatf("t1 rd_addr %0d", k), in_rd_addr, 32'(k));
      check($sformatf("t1 local_addr %0d", k), local_addr, 32'(k));
      if (k > 0) begin
        check($sformatf("t1 valid %0d", k - 1), 32'(input_valid), 32'd1);
        check($sformatf("t1 data %0d", k - 1), 32'(data_in), 32'(16'hA000 + k - 1));
      end else begin
        check("t1 valid first", 32'(input_valid), 32'd0);
      end
    end
    step();  // WAIT cycle 1
    check("t1 rd_en off in wait", 32'(in_rd_en), 32'd0);
    check("t1 last valid", 32'(input_valid), 32'd1);
    check("t1 last data", 32'(data_in), 32'h0000A003);
    check("t1 local_addr held", local_addr, 32'd3);

    // Completion five cycles into WAIT.
    done_base = done_cnt;
    step();  // WAIT cycle 2
    check("t1 valid count", 32'(iv_cnt - iv_base), 32'd4);
    check("t1 valid dropped", 32'(input_valid), 32'd0);
    step();
    step();
    step();  // WAIT cycle 5
    check("t3 waiting busy", 32'(busy), 32'd1);
    check("t3 no early done", 32'(layer_done), 32'd0);
    out_valids = '1;
    step();
    out_valids = '0;
    check("t3 layer_done", 32'(layer_done), 32'd1);
    check("t3 busy in done", 32'(busy), 32'd1);
    step();
    check("t3 done cleared", 32'(layer_done), 32'd0);
    check("t3 busy dropped", 32'(busy), 32'd0);
    check("t3 fault", 32'(fault), 32'd0);
    check("t3 one done pulse", 32'(done_cnt - done_base), 32'd1);

    // Buffer bubbles after index 1.
    iv_base = iv_cnt;
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t2 addr0", in_rd_addr, 32'd0);
    step();
    check("t2 addr1", in_rd_addr, 32'd1);
    in_avail = 1'b0;
    for (int b = 0; b < 3; b++) begin
      step();
      check($sformatf("t2 bubble rd_en %0d", b), 32'(in_rd_en), 32'd0);
      check($sformatf("t2 bubble local_addr %0d", b), local_addr, 32'd1);
    end
    in_avail = 1'b1;
    step();
    check("t2 resume rd_en", 32'(in_rd_en), 32'd1);
    check("t2 resume addr2", in_rd_addr, 32'd2);
    step();
    check("t2 addr3", in_rd_addr, 32'd3);
    check("t2 data2", 32'(data_in), 32'h0000A002);
    step();  // WAIT cycle 1
    check("t2 data3", 32'(data_in), 32'h0000A003);

    // No completion: timeout after sixteen WAIT cycles.
    done_base = done_cnt;
    for (int w = 2; w <= 16; w++) step();
    check("t2 valid count", 32'(iv_cnt - iv_base), 32'd4);
    check("t4 busy at wait 16", 32'(busy), 32'd1);
    check("t4 no fault yet", 32'(fault), 32'd0);
    step();
    check("t4 fault set", 32'(fault), 32'd1);
    check("t4 idle", 32'(busy), 32'd0);
    check("t4 no done", 32'(done_cnt - done_base), 32'd0);
    step();
    check("t4 fault sticky", 32'(fault), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t4 start clears fault", 32'(fault), 32'd0);

    // Abort at index 2.
    iv_base = iv_cnt;
    step();
    step();
    step();
    check("t5 at addr2", in_rd_addr, 32'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5 idle", 32'(busy), 32'd0);
    check("t5 rd_en off", 32'(in_rd_en), 32'd0);
    check("t5 inflight dropped", 32'(input_valid), 32'd0);
    step();
    step();
    check("t5 still quiet", 32'(in_rd_en), 32'd0);
    check("t5 valid count", 32'(iv_cnt - iv_base), 32'd2);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t5 restart addr0", in_rd_addr, 32'd0);
    check("t5 restart rd_en", 32'(in_rd_en), 32'd1);

    // start ignored during STREAM, then rst mid-pass.
    step();
    check("t6 addr1", in_rd_addr, 32'd1);
    start = 1'b1;
    step();
    check("t6 start ignored", in_rd_addr, 32'd2);
    rst   = 1'b1;
    start = 1'b0;
    step();
    check_reset("t6 rst");
    rst = 1'b0;
    step();
    check("t6 stays idle", 32'(busy), 32'd0);
    check("t6 no read", 32'(in_rd_en), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
